decode_stage_hz: RTL and testbench
==================================

# decode_stage_hz

Parametrised RISC-V decode stage with hazard controls and an ID/EX pipeline register. It sits between fetch (IF/ID register) and execute. It decodes the instruction, reads the integrated register file, and extends the immediate for I/S/B/J/U formats. It registers everything into the E stage under stall, flush and bubble control, and flags illegal encodings.

## Interface
- XLEN, 32: datapath width (32 or 64).
- NREGS, 32: architectural registers (16 = RV32E, 32 = RV32I).
- RF_BYPASS, 1: 1 = same-cycle W-to-D read bypass; 0 = no bypass.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- InstrD  in  32  instruction in D.
- PCD, PCPlus4D  in  XLEN  PC and PC+4 of InstrD.
- ValidD  in  1  InstrD carries a real instruction.
- StallE  in  1  hold the ID/EX register.
- FlushE  in  1  load a bubble into the ID/EX register.
- RegWriteW  in  1  writeback enable.
- RDW  in  5  writeback register index.
- ResultW  in  XLEN  writeback data.
- RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  out  1  registered controls.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  out  XLEN  registered operands.
- RS1_E, RS2_E, RD_E  out  5  registered register indices.
- ValidE, IllegalE  out  1  E slot holds an instruction / holds an illegal instruction.

## Operation
- Supported opcodes:
  - 0000011 lw
  - 0100011 sw
  - 0110011 R-type add/sub/and/or/slt
  - 0010011 I-ALU addi/andi/ori/slti
  - 1100011 beq
  - 1101111 jal
  - 0110111 lui
- Funct decode:
  - sub is funct3=000 with funct7[5]=1 on R-type only.
  - I-type funct3=000 is always add.
- lui: ALUSrc=1, ALU add, RD1 forced to 0, Imm = {instr[31:12], 12'b0} sign-extended to XLEN.
- jal: JumpE=1, RegWrite=1, ResultSrc=10, J-immediate.
- beq: BranchE=1, ALU sub, B-immediate. sw: MemWrite=1, S-immediate.
- All immediates are sign-extended from instr[31] to XLEN.
- The following are illegal:
  - any opcode not in the list above
  - an unsupported funct3/funct7
  - any referenced rs1/rs2/rd index ≥ NREGS
- Illegal handling: all write/branch/jump controls are zeroed, IllegalE=1, ValidE=1.
- Register file: NREGS×XLEN; x0 reads 0 and ignores writes.
  - Writes occur at the rising edge when RegWriteW=1, RDW≠0 and RDW<NREGS.
- RF_BYPASS=1: if RegWriteW, RDW≠0 and RDW equals rs1 (or rs2), that read returns ResultW combinationally.
- ValidD=0 is treated as a bubble.
- Bubble contents: all controls 0, ValidE=0, IllegalE=0. Data and index fields are 0.
- Register update priority at each edge: reset > FlushE > StallE (hold) > load.

## Timing
- Reset (rst=0, asynchronous): every E output is 0 and every register file entry is 0. Operation resumes on the first rising edge with rst=1.
- Latency: D inputs appear on E outputs one cycle later.
- Stall: with StallE=1, E outputs hold indefinitely.
  - The register file still writes during a stall.
  - Held RD1_E/RD2_E are not refreshed by later writes; the forwarding unit covers that case.
- FlushE together with StallE: the flush wins and a bubble is loaded.
- Write and read of the same register in one cycle:
  - RF_BYPASS=1: D sees the new value.
  - RF_BYPASS=0: D sees the old value; the new value is visible from the next cycle.
- Reset mid-stall clears the held state immediately.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants
  - ALUControl encodings
  - ResultSrc encodings
  - immediate-format enum (IMM_I/S/B/J/U)
- Sub-module `regfile_bypass`, parametrised by XLEN, NREGS and RF_BYPASS.
- Control decode and immediate extension are combinational in the top. The ID/EX register is in the top.

## Test plan
- Reset, then `addi x1,x0,10` (0x00A00093), then `addi x2,x0,20` (0x01400113), each followed by a W-stage write → Imm_Ext_E = 0xA then 0x14, ALUControlE = 000, RegWriteE = 1.
- With x1=10 and x2=20 written, `add x3,x1,x2` (0x002081B3) → RD1_E = 10, RD2_E = 20. Then `sub x4,x3,x1` (0x40118233) → ALUControlE = 001.
- Bypass: `add` decoded while RegWriteW=1, RDW=1, ResultW=0x55.
  - RF_BYPASS=1 → RD1_E = 0x55 next cycle.
  - RF_BYPASS=0 → RD1_E = the old value.
- Stall and flush: hold StallE=1 for 3 cycles → outputs are constant. Then assert StallE=1 and FlushE=1 together → ValidE = 0, all controls 0.
- Immediates:
  - `beq x5,x4,+8` (0x00428463) → BranchE = 1, Imm_Ext_E = 8.
  - `jal x1,-4` (0xFFDFF0EF) → Imm_Ext_E = 0xFFFFFFFC, ResultSrcE = 10.
  - `lui x5,0x12345` (0x123452B7) → Imm_Ext_E = 0x12345000, RD1_E = 0.
- Illegal cases:
  - opcode 0x7F → IllegalE = 1, RegWriteE = 0.
  - NREGS=16 with `addi x17,x0,1` (0x00100893) → IllegalE = 1.
  - x0 write with ResultW = 0xFFFF → x0 still reads 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU/result-select encodings,
// immediate formats and the 32-bit immediate builder.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_fmt_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src;
        logic [1:0] result_src;
        logic [2:0] alu_control;
        logic       illegal;
    } ctrl_t;

    // Sign-extended 32-bit immediate; the caller widens it to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] instr, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            default: imm32 = 32'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_from_funct3(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  alu_from_funct3 = sub ? ALU_SUB : ALU_ADD;
            3'b010:  alu_from_funct3 = ALU_SLT;
            3'b110:  alu_from_funct3 = ALU_OR;
            3'b111:  alu_from_funct3 = ALU_AND;
            default: alu_from_funct3 = ALU_ADD;
        endcase
    endfunction

    function automatic logic funct3_alu_ok(input logic [2:0] funct3);
        funct3_alu_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                        (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// NREGS x XLEN register file, x0 hardwired to zero, two async read ports
// with optional same-cycle write-to-read bypass.
module regfile_bypass #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      wa,
    input  logic [XLEN-1:0] wd,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);
    localparam int         AW      = $clog2(NREGS);
    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [XLEN-1:0] regs_r [NREGS];
    logic            wr_en_s;

    // Effective write enable: x0 and out-of-range indices are dropped.
    always_comb begin
        wr_en_s = we && (wa != 5'd0) && ({1'b0, wa} < NREGS_L);
    end

    // Storage update; reset clears every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            regs_r[wa[AW-1:0]] <= wd;
        end
    end

    // Read port 1.
    always_comb begin
        rd1 = '0;
        if ((ra1 == 5'd0) || ({1'b0, ra1} >= NREGS_L)) begin
            rd1 = '0;
        end else if ((RF_BYPASS != 0) && wr_en_s && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs_r[ra1[AW-1:0]];
        end
    end

    // Read port 2.
    always_comb begin
        rd2 = '0;
        if ((ra2 == 5'd0) || ({1'b0, ra2} >= NREGS_L)) begin
            rd2 = '0;
        end else if ((RF_BYPASS != 0) && wr_en_s && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs_r[ra2[AW-1:0]];
        end
    end

endmodule

// File: rtl/decode_stage_hz.sv
// RISC-V decode stage: control decode, register read, immediate extension
// and the ID/EX pipeline register with flush/stall/bubble handling.
module decode_stage_hz #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int RF_BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            ValidD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic            ALUSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [4:0]      RD_E,
    output logic            ValidE,
    output logic            IllegalE
);
    import riscv_pkg::*;

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    typedef struct packed {
        ctrl_t           ctrl;
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } idex_t;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    ctrl_t           ctrl_s, dec_ctrl_s;
    imm_fmt_e        fmt_s;
    logic            use_rs1_s, use_rs2_s, use_rd_s, lui_s, enc_ok_s, idx_ok_s;
    logic [XLEN-1:0] rf_rd1_s, rf_rd2_s, imm_s;
    idex_t           idex_next_s, idex_r;

    assign opcode_s = InstrD[6:0];
    assign rd_s     = InstrD[11:7];
    assign funct3_s = InstrD[14:12];
    assign rs1_s    = InstrD[19:15];
    assign rs2_s    = InstrD[24:20];
    assign funct7_s = InstrD[31:25];

    regfile_bypass #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .RF_BYPASS (RF_BYPASS)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW),
        .wa  (RDW),
        .wd  (ResultW),
        .ra1 (rs1_s),
        .ra2 (rs2_s),
        .rd1 (rf_rd1_s),
        .rd2 (rf_rd2_s)
    );

    // Opcode/funct decode into raw controls plus which register fields are referenced.
    always_comb begin
        ctrl_s    = '0;
        fmt_s     = IMM_I;
        use_rs1_s = 1'b0;
        use_rs2_s = 1'b0;
        use_rd_s  = 1'b0;
        lui_s     = 1'b0;
        enc_ok_s  = 1'b0;
        case (opcode_s)
            OP_LOAD: begin
                enc_ok_s          = (funct3_s == 3'b010);
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.alu_src    = 1'b1;
                ctrl_s.result_src = RES_MEM;
                use_rs1_s         = 1'b1;
                use_rd_s          = 1'b1;
            end
            OP_STORE: begin
                enc_ok_s         = (funct3_s == 3'b010);
                ctrl_s.mem_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                fmt_s            = IMM_S;
                use_rs1_s        = 1'b1;
                use_rs2_s        = 1'b1;
            end
            OP_RTYPE: begin
                enc_ok_s           = ((funct7_s == 7'b0000000) && funct3_alu_ok(funct3_s)) ||
                                     ((funct7_s == 7'b0100000) && (funct3_s == 3'b000));
                ctrl_s.reg_write   = 1'b1;
                ctrl_s.alu_control = alu_from_funct3(funct3_s, funct7_s[5]);
                use_rs1_s          = 1'b1;
                use_rs2_s          = 1'b1;
                use_rd_s           = 1'b1;
            end
            OP_IALU: begin
                enc_ok_s           = funct3_alu_ok(funct3_s);
                ctrl_s.reg_write   = 1'b1;
                ctrl_s.alu_src     = 1'b1;
                ctrl_s.alu_control = alu_from_funct3(funct3_s, 1'b0);
                use_rs1_s          = 1'b1;
                use_rd_s           = 1'b1;
            end
            OP_BRANCH: begin
                enc_ok_s           = (funct3_s == 3'b000);
                ctrl_s.branch      = 1'b1;
                ctrl_s.alu_control = ALU_SUB;
                fmt_s              = IMM_B;
                use_rs1_s          = 1'b1;
                use_rs2_s          = 1'b1;
            end
            OP_JAL: begin
                enc_ok_s          = 1'b1;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.jump       = 1'b1;
                ctrl_s.result_src = RES_PC4;
                fmt_s             = IMM_J;
                use_rd_s          = 1'b1;
            end
            OP_LUI: begin
                enc_ok_s         = 1'b1;
                ctrl_s.reg_write = 1'b1;
                ctrl_s.alu_src   = 1'b1;
                fmt_s            = IMM_U;
                lui_s            = 1'b1;
                use_rd_s         = 1'b1;
            end
            default: begin
                enc_ok_s = 1'b0;
            end
        endcase
    end

    // Legality: bad encodings or referenced indices beyond NREGS squash every control.
    always_comb begin
        idx_ok_s = !((use_rs1_s && ({1'b0, rs1_s} >= NREGS_L)) ||
                     (use_rs2_s && ({1'b0, rs2_s} >= NREGS_L)) ||
                     (use_rd_s  && ({1'b0, rd_s}  >= NREGS_L)));
        if (enc_ok_s && idx_ok_s) begin
            dec_ctrl_s = ctrl_s;
        end else begin
            dec_ctrl_s         = '0;
            dec_ctrl_s.illegal = 1'b1;
        end
    end

    assign imm_s = XLEN'($signed(imm32(InstrD, fmt_s)));

    // Next ID/EX contents; ValidD=0 loads an all-zero bubble.
    always_comb begin
        idex_next_s = '0;
        if (ValidD) begin
            idex_next_s.ctrl  = dec_ctrl_s;
            idex_next_s.valid = 1'b1;
            idex_next_s.rd1   = lui_s ? '0 : rf_rd1_s;
            idex_next_s.rd2   = rf_rd2_s;
            idex_next_s.imm   = imm_s;
            idex_next_s.pc    = PCD;
            idex_next_s.pc4   = PCPlus4D;
            idex_next_s.rs1   = rs1_s;
            idex_next_s.rs2   = rs2_s;
            idex_next_s.rd    = rd_s;
        end else begin
            idex_next_s = '0;
        end
    end

    // ID/EX register: flush beats stall, stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_r <= '0;
        end else if (FlushE) begin
            idex_r <= '0;
        end else if (!StallE) begin
            idex_r <= idex_next_s;
        end
    end

    assign RegWriteE   = idex_r.ctrl.reg_write;
    assign MemWriteE   = idex_r.ctrl.mem_write;
    assign BranchE     = idex_r.ctrl.branch;
    assign JumpE       = idex_r.ctrl.jump;
    assign ALUSrcE     = idex_r.ctrl.alu_src;
    assign ResultSrcE  = idex_r.ctrl.result_src;
    assign ALUControlE = idex_r.ctrl.alu_control;
    assign IllegalE    = idex_r.ctrl.illegal;
    assign ValidE      = idex_r.valid;
    assign RD1_E       = idex_r.rd1;
    assign RD2_E       = idex_r.rd2;
    assign Imm_Ext_E   = idex_r.imm;
    assign PCE         = idex_r.pc;
    assign PCPlus4E    = idex_r.pc4;
    assign RS1_E       = idex_r.rs1;
    assign RS2_E       = idex_r.rs2;
    assign RD_E        = idex_r.rd;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Randomized self-checking bench for decode_stage_hz: three instances
// (bypass, no bypass, RV32E) checked against an instruction-level reference model.
module tb_decode_stage_hz;

    typedef struct packed {
        logic        rw, mw, br, jp, as;
        logic [1:0]  rs;
        logic [2:0]  ac;
        logic        v, il;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  i1, i2, id;
    } e_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] InstrD = 32'd0, PCD = 32'd0, PCPlus4D = 32'd0, ResultW = 32'd0;
    logic        ValidD = 1'b0, StallE = 1'b0, FlushE = 1'b0, RegWriteW = 1'b0;
    logic [4:0]  RDW = 5'd0;

    e_t          act   [3];
    e_t          exp_q [3];
    e_t          msk_q [3];
    logic [31:0] mrf   [3][32];
    int          checks = 0;
    int          errs   = 0;
    int          cyc    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic        rw, mw, br, jp, as, v, il;
        logic [1:0]  rs;
        logic [2:0]  ac;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  i1, i2, id;
        decode_stage_hz #(
            .XLEN(32), .NREGS((g == 2) ? 16 : 32), .RF_BYPASS((g == 1) ? 0 : 1)
        ) dut (
            .clk(clk), .rst(rst_n), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
            .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .RegWriteW(RegWriteW),
            .RDW(RDW), .ResultW(ResultW),
            .RegWriteE(rw), .MemWriteE(mw), .BranchE(br), .JumpE(jp), .ALUSrcE(as),
            .ResultSrcE(rs), .ALUControlE(ac), .RD1_E(rd1), .RD2_E(rd2), .Imm_Ext_E(imm),
            .PCE(pc), .PCPlus4E(pc4), .RS1_E(i1), .RS2_E(i2), .RD_E(id),
            .ValidE(v), .IllegalE(il)
        );
        assign act[g] = {rw, mw, br, jp, as, rs, ac, v, il, rd1, rd2, imm, pc, pc4, i1, i2, id};
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errs++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [11:0] ctl(input e_t x);
        return {x.rw, x.mw, x.br, x.jp, x.as, x.rs, x.ac, x.v, x.il};
    endfunction

    function automatic int nregs_of(input int g);
        return (g == 2) ? 16 : 32;
    endfunction

    // Register read as the D stage should see it this cycle.
    function automatic logic [31:0] rdval(input int g, input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if ((g != 1) && RegWriteW && (RDW == idx)) return ResultW;
        return mrf[g][idx];
    endfunction

    function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic sub);
        if (f3 == 3'd0) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        return 3'b010;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            exp_q[g] = '0;
            msk_q[g] = '1;
            for (int r = 0; r < 32; r++) mrf[g][r] = 32'd0;
        end
    endtask

    // One clock edge of the reference: E slot update then register file write.
    task automatic model_step(input int g);
        e_t e, m;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] r1, r2, rd;
        bit u1, u2, ud, ok, has_imm;
        int imm, nr;
        nr = nregs_of(g);
        if (FlushE) begin
            exp_q[g] = '0;
            msk_q[g] = '1;
        end else if (!StallE) begin
            e = '0; m = '0;
            if (!ValidD) begin
                m = '1;
            end else begin
                op = InstrD[6:0]; rd = InstrD[11:7]; f3 = InstrD[14:12];
                r1 = InstrD[19:15]; r2 = InstrD[24:20]; f7 = InstrD[31:25];
                u1 = 0; u2 = 0; ud = 0; ok = 1; has_imm = 1; imm = 0;
                m.as = 1; m.rs = '1; m.ac = '1;
                case (op)
                    7'b0000011: begin
                        ok = (f3 == 3'd2); u1 = 1; ud = 1;
                        e.rw = 1; e.as = 1; e.rs = 2'b01;
                        imm = $signed(InstrD) >>> 20;
                    end
                    7'b0100011: begin
                        ok = (f3 == 3'd2); u1 = 1; u2 = 1;
                        e.mw = 1; e.as = 1; m.rs = '0;
                        imm = (($signed(InstrD) >>> 25) * 32) + int'(rd);
                    end
                    7'b0110011: begin
                        ok = ((f7 == 7'h00) && (f3 inside {3'd0, 3'd2, 3'd6, 3'd7})) ||
                             ((f7 == 7'h20) && (f3 == 3'd0));
                        u1 = 1; u2 = 1; ud = 1; has_imm = 0;
                        e.rw = 1; e.ac = alu_exp(f3, f7[5]);
                    end
                    7'b0010011: begin
                        ok = (f3 inside {3'd0, 3'd2, 3'd6, 3'd7}); u1 = 1; ud = 1;
                        e.rw = 1; e.as = 1; e.ac = alu_exp(f3, 1'b0);
                        imm = $signed(InstrD) >>> 20;
                    end
                    7'b1100011: begin
                        ok = (f3 == 3'd0); u1 = 1; u2 = 1;
                        e.br = 1; e.ac = 3'b001; m.rs = '0;
                        imm = (InstrD[31] ? -4096 : 0) + int'(InstrD[7]) * 2048 +
                              int'(InstrD[30:25]) * 32 + int'(InstrD[11:8]) * 2;
                    end
                    7'b1101111: begin
                        ud = 1; e.rw = 1; e.jp = 1; e.rs = 2'b10; m.as = 0; m.ac = '0;
                        imm = (InstrD[31] ? -(1 << 20) : 0) + int'(InstrD[19:12]) * 4096 +
                              int'(InstrD[20]) * 2048 + int'(InstrD[30:21]) * 2;
                    end
                    7'b0110111: begin
                        ud = 1; e.rw = 1; e.as = 1;
                        m.rd1 = '1;
                        imm = $signed(InstrD) - int'(InstrD[11:0]);
                    end
                    default: ok = 0;
                endcase
                if ((u1 && r1 >= nr) || (u2 && r2 >= nr) || (ud && rd >= nr)) ok = 0;
                if (!ok) begin
                    e = '0; m = '0;
                    e.il = 1;
                end else begin
                    if (u1) begin e.rd1 = rdval(g, r1); m.rd1 = '1; e.i1 = r1; m.i1 = '1; end
                    if (u2) begin e.rd2 = rdval(g, r2); m.rd2 = '1; e.i2 = r2; m.i2 = '1; end
                    if (ud) begin e.id = rd; m.id = '1; end
                    if (has_imm) begin e.imm = imm; m.imm = '1; end
                end
                e.v = 1; e.pc = PCD; e.pc4 = PCPlus4D;
                m.rw = 1; m.mw = 1; m.br = 1; m.jp = 1; m.v = 1; m.il = 1;
                m.pc = '1; m.pc4 = '1;
            end
            exp_q[g] = e;
            msk_q[g] = m;
        end
        if (RegWriteW && (RDW != 5'd0) && (RDW < nr)) mrf[g][RDW] = ResultW;
    endtask

    task automatic check_all();
        e_t a, e, m;
        for (int g = 0; g < 3; g++) begin
            a = act[g]; e = exp_q[g]; m = msk_q[g];
            check_eq($sformatf("ctl[%0d]", g), 64'(ctl(a) & ctl(m)), 64'(ctl(e) & ctl(m)));
            check_eq($sformatf("rd1[%0d]", g), 64'(a.rd1 & m.rd1), 64'(e.rd1 & m.rd1));
            check_eq($sformatf("rd2[%0d]", g), 64'(a.rd2 & m.rd2), 64'(e.rd2 & m.rd2));
            check_eq($sformatf("imm[%0d]", g), 64'(a.imm & m.imm), 64'(e.imm & m.imm));
            check_eq($sformatf("pc[%0d]", g), 64'({a.pc, a.pc4} & {m.pc, m.pc4}),
                     64'({e.pc, e.pc4} & {m.pc, m.pc4}));
            check_eq($sformatf("idx[%0d]", g), 64'({a.i1, a.i2, a.id} & {m.i1, m.i2, m.id}),
                     64'({e.i1, e.i2, e.id} & {m.i1, m.i2, m.id}));
        end
    endtask

    // Apply one cycle of D/W inputs (called at a falling edge), step the model, check.
    task automatic cyc_run(input logic [31:0] ins, input logic v, input logic st, input logic fl,
                           input logic rw, input logic [4:0] rd, input logic [31:0] res);
        InstrD = ins; ValidD = v; StallE = st; FlushE = fl;
        RegWriteW = rw; RDW = rd; ResultW = res;
        PCD = $urandom & 32'hFFFF_FFFC; PCPlus4D = PCD + 32'd4;
        @(posedge clk);
        for (int g = 0; g < 3; g++) model_step(g);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  a, b, d;
        logic [2:0]  f3;
        logic [31:0] r;
        logic [2:0]  f3s [4];
        logic [6:0]  ops [7];
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0110111};
        a = pick_reg(); b = pick_reg(); d = pick_reg();
        r = $urandom; f3 = f3s[$urandom_range(0, 3)];
        case ($urandom_range(0, 9))
            0: return {r[31:20], a, 3'b010, d, 7'b0000011};
            1: return {r[31:25], b, a, 3'b010, r[11:7], 7'b0100011};
            2: return {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, b, a, f3, d, 7'b0110011};
            3: return {r[31:20], a, f3, d, 7'b0010011};
            4: return {r[31:25], b, a, 3'b000, r[11:7], 7'b1100011};
            5: return {r[31:12], d, 7'b1101111};
            6: return {r[31:12], d, 7'b0110111};
            7: return {r[31:7], ops[$urandom_range(0, 6)]};
            8: return r;
            default: return {r[31:25], b, a, f3, d, 7'b0110011};
        endcase
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        cyc_run(32'h00A00093, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("addi10 imm", 64'(act[0].imm), 64'h0000000A);
        check_eq("addi10 alu", 64'(act[0].ac), 64'd0);
        check_eq("addi10 rw", 64'(act[0].rw), 64'd1);
        cyc_run(32'h01400113, 1, 0, 0, 1, 5'd1, 32'd10);
        check_eq("addi20 imm", 64'(act[0].imm), 64'h00000014);
        cyc_run(32'h0, 0, 0, 0, 1, 5'd2, 32'd20);
        cyc_run(32'h002081B3, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("add rd1", 64'(act[0].rd1), 64'd10);
        check_eq("add rd2", 64'(act[0].rd2), 64'd20);
        cyc_run(32'h40118233, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("sub alu", 64'(act[0].ac), 64'd1);
        cyc_run(32'h002081B3, 1, 0, 0, 1, 5'd1, 32'h55);
        check_eq("bypass on rd1", 64'(act[0].rd1), 64'h55);
        check_eq("bypass off rd1", 64'(act[1].rd1), 64'd10);
        cyc_run(32'h002081B3, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("nobypass next rd1", 64'(act[1].rd1), 64'h55);
        for (int i = 0; i < 3; i++) begin
            cyc_run(32'h123452B7, 1, 1, 0, 1, 5'd1, 32'h99);
            check_eq("stall rd1", 64'(act[0].rd1), 64'h55);
            check_eq("stall rd2", 64'(act[0].rd2), 64'd20);
            check_eq("stall valid", 64'(act[0].v), 64'd1);
        end
        cyc_run(32'h00A00093, 1, 1, 1, 0, 5'd0, 32'd0);
        check_eq("flush valid", 64'(act[0].v), 64'd0);
        check_eq("flush ctl", 64'(ctl(act[0])), 64'd0);
        cyc_run(32'h00428463, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("beq br", 64'(act[0].br), 64'd1);
        check_eq("beq imm", 64'(act[0].imm), 64'd8);
        cyc_run(32'hFFDFF0EF, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("jal imm", 64'(act[0].imm), 64'hFFFFFFFC);
        check_eq("jal rsrc", 64'(act[0].rs), 64'd2);
        cyc_run(32'h123452B7, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("lui imm", 64'(act[0].imm), 64'h12345000);
        check_eq("lui rd1", 64'(act[0].rd1), 64'd0);
        cyc_run(32'h0000007F, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("badop ill", 64'(act[0].il), 64'd1);
        check_eq("badop rw", 64'(act[0].rw), 64'd0);
        cyc_run(32'h00100893, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("x17 ill rv32e", 64'(act[2].il), 64'd1);
        check_eq("x17 ok rv32i", 64'(act[0].il), 64'd0);
        cyc_run(32'h000001B3, 1, 0, 0, 1, 5'd0, 32'hFFFF);
        check_eq("x0 bypass", 64'(act[0].rd1), 64'd0);
        cyc_run(32'h000001B3, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("x0 read", 64'(act[2].rd1), 64'd0);

        cyc_run(32'h002081B3, 1, 0, 0, 0, 5'd0, 32'd0);
        StallE = 1'b1;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        check_eq("midstall rst valid", 64'(act[0].v), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_run(32'h002081B3, 1, 0, 0, 0, 5'd0, 32'd0);
        check_eq("rf cleared", 64'(act[0].rd1), 64'd0);

        for (int i = 0; i < 400; i++) begin
            cyc_run(gen_instr(), ($urandom_range(0, 6) != 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
                    pick_reg(), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
